// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared opcodes, frame geometry and defaults for the LED array controller
package led_ctrl_pkg;

    localparam int OPC_W          = 3;
    localparam int ADDR_W_DEF     = 5;
    localparam int BCAST_ADDR_DEF = 31;

    typedef enum logic [OPC_W-1:0] {
        OP_OFF        = 3'd0,
        OP_ON         = 3'd1,
        OP_BLINK_SLOW = 3'd2,
        OP_BLINK_FAST = 3'd3,
        OP_PAT        = 3'd4,
        OP_PAT_N      = 3'd5,
        OP_DIM        = 3'd6,
        OP_RESERVED   = 3'd7
    } led_mode_e;

    function automatic int frame_w(input int addr_w);
        return OPC_W + addr_w;
    endfunction

endpackage

// File: rtl/led_array_ctrl_serial_frame_rx.sv
// rtl/led_array_ctrl_serial_frame_rx.sv - host serial frame receiver: synchronisers, shift register, bit count
module serial_frame_rx #(
    parameter int FRAME_W = 8
) (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic               sclk_i,
    input  logic               data_i,
    input  logic               latch_i,
    output logic               dout_o,
    output logic               commit_o,
    output logic [FRAME_W-1:0] frame_o,
    output logic               len_ok_o
);

    localparam int                CNT_W    = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);

    logic [2:0]         sclk_q;
    logic [2:0]         latch_q;
    logic [1:0]         data_q;
    logic [1:0]         warm_q;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic armed, sclk_rise, latch_rise, shift_en;

    // Edges stay masked until the edge flops have caught up with the synchronised
    // pins, so a LATCH held high across reset release never commits.
    assign armed      = (warm_q == 2'd3);
    assign sclk_rise  = armed & sclk_q[1] & ~sclk_q[2];
    assign latch_rise = armed & latch_q[1] & ~latch_q[2];
    assign shift_en   = sclk_rise & ~latch_q[1];

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (latch_rise) begin
            cnt_d = '0;
        end else if (shift_en) begin
            sr_d = {sr_q[FRAME_W-2:0], data_q[1]};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sclk_q  <= '0;
            latch_q <= '0;
            data_q  <= '0;
            warm_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sclk_q  <= {sclk_q[1:0], sclk_i};
            latch_q <= {latch_q[1:0], latch_i};
            data_q  <= {data_q[0], data_i};
            if (!armed) begin
                warm_q <= warm_q + 1'b1;
            end
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o   = sr_q[FRAME_W-1];
    assign commit_o = latch_rise;
    assign frame_o  = sr_q;
    assign len_ok_o = (cnt_q == CNT_FULL);

endmodule

// File: rtl/led_array_ctrl.sv
// rtl/led_array_ctrl.sv - LED array controller: frame decode, per-channel mode array, timebase, output mux
module led_array_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS   = 23,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int TB_W       = 20,
    parameter int BCAST_ADDR = BCAST_ADDR_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                SCLK,
    input  logic                DATA,
    input  logic                LATCH,
    input  logic                PATTERN,
    output logic [NUM_LEDS-1:0] LED,
    output logic                DOUT,
    output logic                FRAME_OK,
    output logic                FRAME_ERR
);

    localparam int                FRAME_W = frame_w(ADDR_W);
    localparam logic [ADDR_W-1:0] NUM_A   = ADDR_W'(NUM_LEDS);
    localparam logic [ADDR_W-1:0] BCAST_A = ADDR_W'(BCAST_ADDR);

    logic               commit, len_ok;
    logic [FRAME_W-1:0] frame;
    logic [OPC_W-1:0]   opcode;
    logic [ADDR_W-1:0]  addr;

    led_mode_e          mode_q [NUM_LEDS];
    led_mode_e          mode_d [NUM_LEDS];
    logic [TB_W-1:0]    tb_q;
    logic [1:0]         pat_q;
    logic [NUM_LEDS-1:0] led_d;
    logic               ok_d, err_d;
    logic               slow, fast, dim;

    serial_frame_rx #(.FRAME_W(FRAME_W)) u_rx (
        .clk_i    (CLK),
        .resetn_i (RESET),
        .sclk_i   (SCLK),
        .data_i   (DATA),
        .latch_i  (LATCH),
        .dout_o   (DOUT),
        .commit_o (commit),
        .frame_o  (frame),
        .len_ok_o (len_ok)
    );

    assign opcode = frame[FRAME_W-1 -: OPC_W];
    assign addr   = frame[ADDR_W-1:0];

    always_comb begin
        mode_d = mode_q;
        ok_d   = 1'b0;
        err_d  = 1'b0;
        if (commit) begin
            if (len_ok && addr == BCAST_A) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    mode_d[i] = led_mode_e'(opcode);
                end
                ok_d = 1'b1;
            end else if (len_ok && addr < NUM_A) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (addr == ADDR_W'(i)) begin
                        mode_d[i] = led_mode_e'(opcode);
                    end
                end
                ok_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign slow = tb_q[TB_W-1];
    assign fast = tb_q[TB_W-3];
    assign dim  = (tb_q[1:0] == 2'b00);

    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_q[i])
                OP_OFF:        led_d[i] = 1'b0;
                OP_ON:         led_d[i] = 1'b1;
                OP_BLINK_SLOW: led_d[i] = slow;
                OP_BLINK_FAST: led_d[i] = fast;
                OP_PAT:        led_d[i] = pat_q[1];
                OP_PAT_N:      led_d[i] = ~pat_q[1];
                OP_DIM:        led_d[i] = dim;
                default:       led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            mode_q    <= '{default: OP_OFF};
            LED       <= '0;
            FRAME_OK  <= 1'b0;
            FRAME_ERR <= 1'b0;
            tb_q      <= '0;
            pat_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            LED       <= led_d;
            FRAME_OK  <= ok_d;
            FRAME_ERR <= err_d;
            tb_q      <= tb_q + 1'b1;
            pat_q     <= {pat_q[0], PATTERN};
        end
    end

endmodule

// File: tb/tb_led_array_ctrl.sv
// tb/tb_led_array_ctrl.sv - directed self-checking bench for led_array_ctrl
module tb_led_array_ctrl;

    localparam int N = 23;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         SCLK = 1'b0;
    logic         DATA = 1'b0;
    logic         LATCH = 1'b0;
    logic         PATTERN = 1'b0;
    logic [N-1:0] LED;
    logic         DOUT, FRAME_OK, FRAME_ERR;

    int checks = 0;
    int passed = 0;
    int ok_cnt = 0;
    int err_cnt = 0;

    logic [3:0] tb_m = '0;
    logic       slow_m = 1'b0;
    logic       dim_m = 1'b0;

    led_array_ctrl #(.NUM_LEDS(N), .ADDR_W(5), .TB_W(4), .BCAST_ADDR(31)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SCLK      (SCLK),
        .DATA      (DATA),
        .LATCH     (LATCH),
        .PATTERN   (PATTERN),
        .LED       (LED),
        .DOUT      (DOUT),
        .FRAME_OK  (FRAME_OK),
        .FRAME_ERR (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    // Reference timebase: LED is registered from the counter value before each edge.
    always @(posedge CLK) begin
        tb_m   <= RESET ? tb_m + 4'd1 : 4'd0;
        slow_m <= tb_m[3];
        dim_m  <= (tb_m[1:0] == 2'b00);
    end

    always @(negedge CLK) begin
        ok_cnt  <= ok_cnt + int'(FRAME_OK);
        err_cnt <= err_cnt + int'(FRAME_ERR);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        tick(2);
        RESET = 1'b1;
        tick(1);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            DATA = v[i];
            tick(3);
            SCLK = 1'b1;
            tick(3);
            SCLK = 1'b0;
            tick(3);
        end
    endtask

    task automatic latch_pulse();
        LATCH = 1'b1;
        tick(6);
        LATCH = 1'b0;
        tick(6);
    endtask

    task automatic test_reset();
        int ok0, err0;
        LATCH = 1'b1;
        SCLK  = 1'b1;
        RESET = 1'b0;
        tick(3);
        checks++;
        if ({LED, DOUT, FRAME_OK, FRAME_ERR} !== '0)
            $display("FAIL reset_outputs: got LED=%h DOUT=%b OK=%b ERR=%b, expected all 0", LED, DOUT, FRAME_OK, FRAME_ERR);
        else passed++;
        ok0 = ok_cnt; err0 = err_cnt;
        RESET = 1'b1;
        tick(10);
        checks++;
        if (ok_cnt != ok0 || err_cnt != err0)
            $display("FAIL reset_latch_held: got %0d ok / %0d err pulses, expected 0/0", ok_cnt - ok0, err_cnt - err0);
        else passed++;
        LATCH = 1'b0;
        SCLK  = 1'b0;
        tick(6);
    endtask

    task automatic test_single();
        int ok0, err0;
        do_reset();
        send_bits(8'h21, 8);
        ok0 = ok_cnt; err0 = err_cnt;
        LATCH = 1'b1;
        tick(2);
        checks++;
        if (FRAME_OK !== 1'b0)
            $display("FAIL single_ok_early: FRAME_OK=%b after 2 cycles, expected 0", FRAME_OK);
        else passed++;
        tick(1);
        checks++;
        if (FRAME_OK !== 1'b1 || LED !== '0)
            $display("FAIL single_cycle3: OK=%b LED=%h, expected OK=1 LED=0", FRAME_OK, LED);
        else passed++;
        tick(1);
        checks++;
        if (FRAME_OK !== 1'b0 || LED !== 23'h000002)
            $display("FAIL single_cycle4: OK=%b LED=%h, expected OK=0 LED=000002", FRAME_OK, LED);
        else passed++;
        tick(4);
        LATCH = 1'b0;
        tick(6);
        checks++;
        if (ok_cnt - ok0 != 1 || err_cnt != err0)
            $display("FAIL single_pulses: got %0d ok / %0d err, expected 1/0", ok_cnt - ok0, err_cnt - err0);
        else passed++;
    endtask

    task automatic test_broadcast();
        int ok0, highs, bad;
        do_reset();
        send_bits(8'h5F, 8);
        ok0 = ok_cnt;
        latch_pulse();
        checks++;
        if (ok_cnt - ok0 != 1)
            $display("FAIL bcast_ok: got %0d ok pulses, expected 1", ok_cnt - ok0);
        else passed++;
        highs = 0; bad = 0;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            if (LED !== {N{slow_m}}) bad++;
            if (LED[0] === 1'b1) highs++;
        end
        checks++;
        if (bad != 0 || highs != 8)
            $display("FAIL bcast_slow: %0d cycles off model, %0d high cycles, expected 0 and 8", bad, highs);
        else passed++;
    endtask

    task automatic test_short_frame();
        int ok0, err0;
        do_reset();
        send_bits(8'h21, 7);
        ok0 = ok_cnt; err0 = err_cnt;
        latch_pulse();
        checks++;
        if (err_cnt - err0 != 1 || ok_cnt != ok0 || LED !== '0)
            $display("FAIL short_frame: %0d err %0d ok LED=%h, expected 1 err 0 ok LED=0", err_cnt - err0, ok_cnt - ok0, LED);
        else passed++;
        send_bits(8'h20, 8);
        ok0 = ok_cnt;
        latch_pulse();
        checks++;
        if (ok_cnt - ok0 != 1 || LED !== 23'h000001)
            $display("FAIL after_short: %0d ok LED=%h, expected 1 ok LED=000001", ok_cnt - ok0, LED);
        else passed++;
    endtask

    task automatic test_addr_range();
        int ok0, err0;
        do_reset();
        send_bits(8'h21, 8);
        latch_pulse();
        err0 = err_cnt;
        send_bits(8'h3E, 8);
        latch_pulse();
        checks++;
        if (err_cnt - err0 != 1 || LED !== 23'h000002)
            $display("FAIL addr30: %0d err LED=%h, expected 1 err LED=000002", err_cnt - err0, LED);
        else passed++;
        err0 = err_cnt;
        send_bits(8'h37, 8);
        latch_pulse();
        checks++;
        if (err_cnt - err0 != 1 || LED !== 23'h000002)
            $display("FAIL addr23: %0d err LED=%h, expected 1 err LED=000002", err_cnt - err0, LED);
        else passed++;
        ok0 = ok_cnt;
        send_bits(8'h36, 8);
        latch_pulse();
        checks++;
        if (ok_cnt - ok0 != 1 || LED !== 23'h400002)
            $display("FAIL addr22: %0d ok LED=%h, expected 1 ok LED=400002", ok_cnt - ok0, LED);
        else passed++;
    endtask

    task automatic test_dim_pattern();
        int highs, bad;
        do_reset();
        send_bits(8'hC3, 8);
        latch_pulse();
        highs = 0; bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (LED[3] !== dim_m || (LED & ~23'h000008) !== '0) bad++;
            if (LED[3] === 1'b1) highs++;
        end
        checks++;
        if (bad != 0 || highs != 2)
            $display("FAIL dim: %0d cycles off model, %0d high cycles, expected 0 and 2", bad, highs);
        else passed++;
        PATTERN = 1'b0;
        send_bits(8'h83, 8);
        latch_pulse();
        checks++;
        if (LED !== '0)
            $display("FAIL pat_low: LED=%h, expected 0", LED);
        else passed++;
        for (int p = 0; p < 2; p++) begin
            PATTERN = (p == 0);
            tick(2);
            checks++;
            if (LED[3] !== ~PATTERN)
                $display("FAIL pat_delay2_%0d: LED[3]=%b, expected %b", p, LED[3], ~PATTERN);
            else passed++;
            tick(1);
            checks++;
            if (LED[3] !== PATTERN)
                $display("FAIL pat_delay3_%0d: LED[3]=%b, expected %b", p, LED[3], PATTERN);
            else passed++;
            tick(2);
        end
    endtask

    task automatic test_midframe_reset();
        int ok0, err0;
        do_reset();
        send_bits(8'h8F, 8);
        latch_pulse();
        send_bits(8'h0A, 4);
        checks++;
        if (DOUT !== 1'b1)
            $display("FAIL dout_fwd: DOUT=%b, expected 1", DOUT);
        else passed++;
        RESET = 1'b0;
        tick(1);
        RESET = 1'b1;
        tick(1);
        checks++;
        if (DOUT !== 1'b0 || LED !== '0)
            $display("FAIL mid_reset: DOUT=%b LED=%h, expected 0 and 0", DOUT, LED);
        else passed++;
        send_bits(8'h22, 8);
        ok0 = ok_cnt; err0 = err_cnt;
        LATCH = 1'b1;
        tick(6);
        DATA = 1'b1;
        for (int i = 0; i < 8; i++) begin
            SCLK = 1'b1;
            tick(3);
            SCLK = 1'b0;
            tick(3);
        end
        checks++;
        if (DOUT !== 1'b0)
            $display("FAIL sclk_in_latch: DOUT=%b, expected 0", DOUT);
        else passed++;
        LATCH = 1'b0;
        tick(6);
        checks++;
        if (ok_cnt - ok0 != 1 || err_cnt != err0 || LED !== 23'h000004)
            $display("FAIL after_reset_frame: %0d ok %0d err LED=%h, expected 1/0 LED=000004", ok_cnt - ok0, err_cnt - err0, LED);
        else passed++;
        send_bits(8'h20, 8);
        ok0 = ok_cnt;
        latch_pulse();
        checks++;
        if (ok_cnt - ok0 != 1 || LED !== 23'h000005)
            $display("FAIL count_after_latch_sclk: %0d ok LED=%h, expected 1 ok LED=000005", ok_cnt - ok0, LED);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_broadcast();
        test_short_frame();
        test_addr_range();
        test_dim_pattern();
        test_midframe_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
